// File: rtl/inv_add_key_mix_columns.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inv_add_key_mix_columns                                                  |
// | AES decryption round back half: AddRoundKey then column-serial           |
// | InvMixColumns (bypassed on the final round), valid/ready on both sides.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inv_add_key_mix_columns #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data,
  input  logic [127:0] round_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] result
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_mix      = 2'd1;
  localparam logic [1:0] c_done     = 2'd2;
  localparam logic [1:0] c_last_col = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] c_step     = 2'(COLS_PER_CYCLE);

  logic [1:0]   r_fsm;
  logic [1:0]   w_fsm_next;
  logic [1:0]   r_col_cnt;
  logic [127:0] r_state;
  logic [127:0] w_mixed_state;
  logic         r_live;
  logic         w_accept;
  logic         w_release;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9, b, d, e are assembled from the x2/x4/x8 chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Only the columns covered by the current beat are replaced.
  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic w_sel;
      assign w_sel = (3'(c) >= {1'b0, r_col_cnt}) &&
                     (3'(c) <  ({1'b0, r_col_cnt} + 3'(COLS_PER_CYCLE)));
      assign w_mixed_state[127-32*c -: 32] = w_sel ? inv_mix_col(r_state[127-32*c -: 32])
                                                   : r_state[127-32*c -: 32];
    end
  endgenerate

  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;
  assign result    = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= c_idle;
    else     r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      c_idle:  if (w_accept) w_fsm_next = in_last ? c_done : c_mix;
      c_mix:   if (r_col_cnt == c_last_col) w_fsm_next = c_done;
      c_done: begin
        if (w_accept)       w_fsm_next = in_last ? c_done : c_mix;
        else if (w_release) w_fsm_next = c_idle;
      end
      default: w_fsm_next = c_idle;
    endcase
  end

  // r_live holds in_ready low until the first edge after reset is released.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_fsm)
      c_idle:  in_ready = r_live;
      c_done: begin
        in_ready  = r_live & out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live    <= 1'b0;
      r_col_cnt <= 2'd0;
      r_state   <= 128'h0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_col_cnt <= 2'd0;
        r_state   <= data ^ round_key;
      end else if (r_fsm == c_mix) begin
        r_col_cnt <= r_col_cnt + c_step;
        r_state   <= w_mixed_state;
      end
    end
  end

endmodule
`default_nettype wire
